// File: rtl/rgb_pwm_pkg.sv
// Shared widths, counter limits and RGB field positions for the RGB PWM driver.
package rgb_pwm_pkg;

    localparam int unsigned CW      = 8;
    localparam int unsigned RGB_W   = 3 * CW;
    localparam logic [CW-1:0] CNT_MAX = 8'd254;

    localparam int unsigned R_MSB = 23;
    localparam int unsigned R_LSB = 16;
    localparam int unsigned G_MSB = 15;
    localparam int unsigned G_LSB = 8;
    localparam int unsigned B_MSB = 7;
    localparam int unsigned B_LSB = 0;

    typedef logic [CW-1:0] duty_t;

endpackage

// File: rtl/rgb_pwm_driver_pwm_channel.sv
// One PWM channel: duty register loaded at period boundaries, compared against
// the shared period counter, registered output.
module pwm_channel
    import rgb_pwm_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          load,
    input  logic [CW-1:0] duty_in,
    input  logic [CW-1:0] cnt,
    output logic          pwm
);

    duty_t duty_q, duty_d;
    logic  pwm_q,  pwm_d;

    always_comb begin
        duty_d = duty_q;
        if (load) begin
            duty_d = duty_in;
        end
        // Counter never reaches 255, so duty 255 stays high for the whole period.
        pwm_d = enable && (cnt < duty_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_q <= '0;
            pwm_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel RGB LED PWM driver; new colours wait in a hold register and are
// applied only at a period boundary so no period is ever glitched.
module rgb_pwm_driver
    import rgb_pwm_pkg::*;
#(
    parameter int unsigned PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             rgb_valid,
    input  logic [RGB_W-1:0] rgb,
    output logic             pwm_r,
    output logic             pwm_g,
    output logic             pwm_b,
    output logic             period_start,
    output logic             pending
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]    pre_q,   pre_d;
    duty_t            cnt_q,   cnt_d;
    logic [RGB_W-1:0] hold_q,  hold_d;
    logic             pend_q,  pend_d;
    logic             pstart_q, pstart_d;

    logic tick;
    logic boundary;
    logic load;

    assign tick     = enable && (pre_q == PRE_LAST);
    assign boundary = tick && (cnt_q == CNT_MAX);
    assign load     = boundary && pend_q;

    always_comb begin
        pre_d = pre_q;
        if (enable) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
        end

        cnt_d = cnt_q;
        if (tick) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        end

        // A strobe coinciding with the boundary wins over the clear: the old hold
        // is loaded into the duties while the new colour stays pending.
        hold_d = hold_q;
        pend_d = pend_q;
        if (rgb_valid) begin
            hold_d = rgb;
            pend_d = 1'b1;
        end else if (load) begin
            pend_d = 1'b0;
        end

        pstart_d = boundary;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q    <= '0;
            cnt_q    <= '0;
            hold_q   <= '0;
            pend_q   <= 1'b0;
            pstart_q <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
            pend_q   <= pend_d;
            pstart_q <= pstart_d;
        end
    end

    pwm_channel u_ch_r (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .load    (load),
        .duty_in (hold_q[R_MSB:R_LSB]),
        .cnt     (cnt_q),
        .pwm     (pwm_r)
    );

    pwm_channel u_ch_g (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .load    (load),
        .duty_in (hold_q[G_MSB:G_LSB]),
        .cnt     (cnt_q),
        .pwm     (pwm_g)
    );

    pwm_channel u_ch_b (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .load    (load),
        .duty_in (hold_q[B_MSB:B_LSB]),
        .cnt     (cnt_q),
        .pwm     (pwm_b)
    );

    assign period_start = pstart_q;
    assign pending      = pend_q;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed bench for rgb_pwm_driver: PRESCALE=1 instance for most checks and a
// PRESCALE=4 instance sharing the same stimulus for the prescaler check.
module tb_rgb_pwm_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        rgb_valid;
    logic [23:0] rgb;

    logic pwm_r1, pwm_g1, pwm_b1, ps1, pend1;
    logic pwm_r4, pwm_g4, pwm_b4, ps4, pend4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rgb_pwm_driver #(.PRESCALE(1)) dut1 (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .rgb_valid    (rgb_valid),
        .rgb          (rgb),
        .pwm_r        (pwm_r1),
        .pwm_g        (pwm_g1),
        .pwm_b        (pwm_b1),
        .period_start (ps1),
        .pending      (pend1)
    );

    rgb_pwm_driver #(.PRESCALE(4)) dut4 (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .rgb_valid    (rgb_valid),
        .rgb          (rgb),
        .pwm_r        (pwm_r4),
        .pwm_g        (pwm_g4),
        .pwm_b        (pwm_b4),
        .period_start (ps4),
        .pending      (pend4)
    );

    typedef struct {
        logic [23:0] rgb;
        int          r;
        int          g;
        int          b;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic strobe(input logic [23:0] v);
        rgb       = v;
        rgb_valid = 1'b1;
        @(negedge clk);
        rgb_valid = 1'b0;
    endtask

    task automatic wait_ps(input bit slow);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (slow ? ps4 : ps1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("period_start_seen", int'(ok), 1);
    endtask

    // Samples the 255 cycles after a period_start; the last sample is the next period_start.
    task automatic count_period(output int hr, output int hg, output int hb,
                                output int lr, output int lg, output int lb);
        bit sr, sg, sb;
        hr = 0; hg = 0; hb = 0; lr = 0; lg = 0; lb = 0;
        sr = 1'b1; sg = 1'b1; sb = 1'b1;
        for (int k = 1; k <= 255; k++) begin
            @(negedge clk);
            hr += int'(pwm_r1); hg += int'(pwm_g1); hb += int'(pwm_b1);
            if (pwm_r1 && sr) lr++; else sr = 1'b0;
            if (pwm_g1 && sg) lg++; else sg = 1'b0;
            if (pwm_b1 && sb) lb++; else sb = 1'b0;
        end
        chk("period_end_start", int'(ps1), 1);
    endtask

    initial begin
        vec_t vecs[6];
        int hr, hg, hb, lr, lg, lb;
        int nps, first_ps, last_ps, highs, cyc;

        vecs[0] = '{24'hFF8000, 255, 128, 0};
        vecs[1] = '{24'h000000, 0, 0, 0};
        vecs[2] = '{24'h0000FF, 0, 0, 255};
        vecs[3] = '{24'h010203, 1, 2, 3};
        vecs[4] = '{24'hFEFF7F, 254, 255, 127};
        vecs[5] = '{24'h404040, 64, 64, 64};

        rst = 1'b1; enable = 1'b1; rgb_valid = 1'b0; rgb = '0;
        #1;
        chk("reset_pwm", int'({pwm_r1, pwm_g1, pwm_b1}), 0);
        chk("reset_ps_pending", int'({ps1, pend1}), 0);
        @(negedge clk);
        rst = 1'b0;

        // Reset mid-run with pwm_r high and a colour pending.
        strobe(24'hFF0000);
        wait_ps(1'b0);
        repeat (5) @(negedge clk);
        chk("pre_reset_pwm_r", int'(pwm_r1), 1);
        strobe(24'h00FF00);
        chk("pre_reset_pending", int'(pend1), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_pwm", int'({pwm_r1, pwm_g1, pwm_b1}), 0);
        chk("async_reset_pending", int'(pend1), 0);
        @(negedge clk);
        rst = 1'b0;
        nps = 0; first_ps = -1; last_ps = -1; highs = 0;
        for (int k = 1; k <= 800; k++) begin
            @(negedge clk);
            highs += int'(pwm_r1) + int'(pwm_g1) + int'(pwm_b1);
            if (ps1) begin
                nps++;
                if (first_ps < 0) first_ps = k;
                last_ps = k;
            end
        end
        chk("post_reset_pwm_highs", highs, 0);
        chk("post_reset_ps_count", nps, 3);
        chk("post_reset_first_ps", first_ps, 255);
        chk("post_reset_last_ps", last_ps, 765);

        // Table-driven duty patterns.
        foreach (vecs[i]) begin
            strobe(vecs[i].rgb);
            chk("vec_pending_set", int'(pend1), 1);
            wait_ps(1'b0);
            chk("vec_pending_clear", int'(pend1), 0);
            count_period(hr, hg, hb, lr, lg, lb);
            chk("vec_r_high", hr, vecs[i].r);
            chk("vec_g_high", hg, vecs[i].g);
            chk("vec_b_high", hb, vecs[i].b);
            chk("vec_r_lead", lr, vecs[i].r);
            chk("vec_g_lead", lg, vecs[i].g);
            chk("vec_b_lead", lb, vecs[i].b);
        end

        // Duty 0x40 running; strobe 0x101010 at cnt=10 must not disturb this period.
        hr = 0; hg = 0; hb = 0;
        for (int k = 1; k <= 255; k++) begin
            @(negedge clk);
            hr += int'(pwm_r1); hg += int'(pwm_g1); hb += int'(pwm_b1);
            if (k == 10) begin
                rgb = 24'h101010; rgb_valid = 1'b1;
            end else if (k == 11) begin
                rgb_valid = 1'b0;
                chk("midstrobe_pending", int'(pend1), 1);
            end
        end
        chk("midstrobe_ps", int'(ps1), 1);
        chk("midstrobe_cur_r", hr, 64);
        chk("midstrobe_cur_g", hg, 64);
        chk("midstrobe_cur_b", hb, 64);
        count_period(hr, hg, hb, lr, lg, lb);
        chk("midstrobe_next_r", hr, 16);
        chk("midstrobe_next_g", hg, 16);
        chk("midstrobe_next_b", hb, 16);

        // Two strobes in one period: last value wins.
        strobe(24'h200000);
        repeat (20) @(negedge clk);
        strobe(24'hC00000);
        wait_ps(1'b0);
        count_period(hr, hg, hb, lr, lg, lb);
        chk("last_wins_r", hr, 192);

        // Strobe on the boundary cycle: old hold loads, new one stays pending.
        strobe(24'h300000);
        for (int k = 2; k <= 254; k++) begin
            @(negedge clk);
            if (k == 254) begin
                rgb = 24'h0A0000; rgb_valid = 1'b1;
            end
        end
        @(negedge clk);
        rgb_valid = 1'b0;
        chk("boundary_strobe_ps", int'(ps1), 1);
        chk("boundary_strobe_pending", int'(pend1), 1);
        count_period(hr, hg, hb, lr, lg, lb);
        chk("boundary_old_hold_r", hr, 48);
        chk("boundary_pending_clear", int'(pend1), 0);
        count_period(hr, hg, hb, lr, lg, lb);
        chk("boundary_new_hold_r", hr, 10);

        // Enable dropped at cnt=100 for 50 cycles, then resume from 100.
        strobe(24'hFFFFFF);
        wait_ps(1'b0);
        repeat (100) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("disable_pwm_low", int'({pwm_r1, pwm_g1, pwm_b1}), 0);
        nps = 0; highs = 0;
        for (int k = 0; k < 49; k++) begin
            @(negedge clk);
            nps += int'(ps1);
            highs += int'(pwm_r1) + int'(pwm_g1) + int'(pwm_b1);
        end
        chk("disable_no_ps", nps, 0);
        chk("disable_pwm_highs", highs, 0);
        enable = 1'b1;
        cyc = 0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (k == 1) chk("reenable_pwm_r", int'(pwm_r1), 1);
            if (ps1) begin
                cyc = k;
                break;
            end
        end
        chk("reenable_ps_delay", cyc, 155);

        // PRESCALE=4 instance: 1020-cycle periods, duty 0x80 -> 512 high cycles.
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        strobe(24'h808080);
        wait_ps(1'b1);
        cyc = 0; highs = 0;
        for (int k = 1; k <= 2000; k++) begin
            @(negedge clk);
            highs += int'(pwm_r4);
            if (ps4) begin
                cyc = k;
                break;
            end
        end
        chk("presc4_period", cyc, 1020);
        chk("presc4_r_high", highs, 512);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
